// File: rtl/burst_memory_ctrl.sv
// burst_memory_ctrl
// Word-organised backing store sitting behind the cache/MESI controller.
// Serves single-beat and BURST_LEN-beat reads and writes. Bursts start at
// the critical word and wrap inside the BURST_LEN-aligned block. Writes use
// per-byte strobes. Requests whose word index is >= DEPTH still complete
// the full handshake: reads return zero data, writes change nothing, and
// err is raised on the final read beat or on the wr_done pulse.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low reset
//   req_valid    request present           / req_ready  accepted while IDLE
//   req_write    1 = write, 0 = read       / req_single 1 = one beat
//   req_addr     byte address of the critical word (low bits ignored)
//   wdata_valid  write beat present        / wdata_ready  write beat taken
//   wdata, wstrb write beat data and byte enables
//   rdata_valid  read beat present         / rdata_ready  consumer takes beat
//   rdata, rlast read beat data, final-beat marker
//   wr_done      one-cycle pulse when a write burst completes
//   err          out-of-range flag, valid with rlast or wr_done
module burst_memory_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int DEPTH     = 4096,
    parameter int BURST_LEN = 4,
    parameter int READ_LAT  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_single,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  wdata_valid,
    output logic                  wdata_ready,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic                  rdata_valid,
    input  logic                  rdata_ready,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rlast,
    output logic                  wr_done,
    output logic                  err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int MEM_W = $clog2(DEPTH);
    localparam int BL_W  = $clog2(BURST_LEN);
    localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        RD_WAIT,
        RD_BEAT,
        WR_BEAT,
        WR_RESP
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [MEM_W-1:0]    base;
    logic                single;
    logic                err_lat;
    logic [BL_W-1:0]     beat;
    logic [LAT_W-1:0]    lat_cnt;

    logic [IDX_W-1:0]    req_idx;
    logic                unused_addr_bits;
    logic [BL_W-1:0]     beat_nx;
    logic                last_beat;
    logic                next_last;
    logic [MEM_W-1:0]    cur_word;
    logic [MEM_W-1:0]    next_word;
    logic [DATA_W-1:0]   rd_cur;
    logic [DATA_W-1:0]   rd_next;

    // Word k of a burst stays inside the aligned block that holds the base.
    function automatic logic [MEM_W-1:0] wrap_word(input logic [MEM_W-1:0] b,
                                                   input logic [BL_W-1:0] k);
        logic [MEM_W-1:0] mask;
        mask = MEM_W'(BURST_LEN - 1);
        return (b & ~mask) | ((b + MEM_W'(k)) & mask);
    endfunction

    assign req_idx          = req_addr[ADDR_W-1:OFF_W];
    assign unused_addr_bits = ^req_addr[OFF_W-1:0];
    assign req_ready        = (state == IDLE);

    assign beat_nx   = beat + BL_W'(1);
    assign last_beat = single || (beat == BL_W'(BURST_LEN - 1));
    assign next_last = (beat_nx == BL_W'(BURST_LEN - 1));
    assign cur_word  = wrap_word(base, beat);
    assign next_word = wrap_word(base, beat_nx);

    // Out-of-range reads must never leak store contents.
    assign rd_cur  = err_lat ? '0 : mem[cur_word];
    assign rd_next = err_lat ? '0 : mem[next_word];

    // Only the store index bits are kept; the range check happens at accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            base        <= '0;
            single      <= 1'b0;
            err_lat     <= 1'b0;
            beat        <= '0;
            lat_cnt     <= '0;
            rdata_valid <= 1'b0;
            rdata       <= '0;
            rlast       <= 1'b0;
            wdata_ready <= 1'b0;
            wr_done     <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base    <= req_idx[MEM_W-1:0];
                        single  <= req_single;
                        err_lat <= (req_idx >= IDX_W'(DEPTH));
                        beat    <= '0;
                        if (req_write) begin
                            state       <= WR_BEAT;
                            wdata_ready <= 1'b1;
                        end else if (READ_LAT == 0) begin
                            state <= RD_BEAT;
                        end else begin
                            state   <= RD_WAIT;
                            lat_cnt <= LAT_W'(READ_LAT - 1);
                        end
                    end
                end
                RD_WAIT: begin
                    if (lat_cnt == '0) begin
                        state <= RD_BEAT;
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                RD_BEAT: begin
                    // The first cycle in RD_BEAT is the store access; after
                    // that each handshake loads the following beat directly.
                    if (!rdata_valid) begin
                        rdata_valid <= 1'b1;
                        rdata       <= rd_cur;
                        rlast       <= last_beat;
                        err         <= err_lat && last_beat;
                    end else if (rdata_ready) begin
                        if (rlast) begin
                            rdata_valid <= 1'b0;
                            rlast       <= 1'b0;
                            err         <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            beat  <= beat_nx;
                            rdata <= rd_next;
                            rlast <= next_last;
                            err   <= err_lat && next_last;
                        end
                    end
                end
                WR_BEAT: begin
                    if (wdata_valid) begin
                        if (last_beat) begin
                            wdata_ready <= 1'b0;
                            wr_done     <= 1'b1;
                            err         <= err_lat;
                            state       <= WR_RESP;
                        end else begin
                            beat <= beat_nx;
                        end
                    end
                end
                WR_RESP: begin
                    wr_done <= 1'b0;
                    err     <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Store write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (state == WR_BEAT && wdata_valid && !err_lat) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb[i]) begin
                    mem[cur_word][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_burst_memory_ctrl.sv
// tb_burst_memory_ctrl
// Self-checking bench for burst_memory_ctrl. Two instances share every input
// except req_valid: the main one uses READ_LAT = 2, the second READ_LAT = 0.
// sel_z routes the request and the observed outputs to the selected instance.
`timescale 1ns/1ps
module tb_burst_memory_ctrl;

    localparam int DEPTH = 4096;
    localparam int BL    = 4;
    localparam int RL    = 2;
    localparam int RLZ   = 0;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_write;
    logic        req_single;
    logic [31:0] req_addr;
    logic        wdata_valid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rdata_ready;
    bit          sel_z;

    logic        m_req_valid, m_req_ready, m_wdata_ready, m_rdata_valid, m_rlast, m_wr_done, m_err;
    logic [31:0] m_rdata;
    logic        z_req_valid, z_req_ready, z_wdata_ready, z_rdata_valid, z_rlast, z_wr_done, z_err;
    logic [31:0] z_rdata;

    logic        req_ready, wdata_ready, rdata_valid, rlast, wr_done, err;
    logic [31:0] rdata;

    assign m_req_valid = req_valid && !sel_z;
    assign z_req_valid = req_valid && sel_z;
    assign req_ready   = sel_z ? z_req_ready   : m_req_ready;
    assign wdata_ready = sel_z ? z_wdata_ready : m_wdata_ready;
    assign rdata_valid = sel_z ? z_rdata_valid : m_rdata_valid;
    assign rdata       = sel_z ? z_rdata       : m_rdata;
    assign rlast       = sel_z ? z_rlast       : m_rlast;
    assign wr_done     = sel_z ? z_wr_done     : m_wr_done;
    assign err         = sel_z ? z_err         : m_err;

    burst_memory_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BURST_LEN(BL), .READ_LAT(RL)) dut (
        .clk(clk), .reset(reset),
        .req_valid(m_req_valid), .req_ready(m_req_ready), .req_write(req_write),
        .req_single(req_single), .req_addr(req_addr),
        .wdata_valid(wdata_valid), .wdata_ready(m_wdata_ready), .wdata(wdata), .wstrb(wstrb),
        .rdata_valid(m_rdata_valid), .rdata_ready(rdata_ready), .rdata(m_rdata), .rlast(m_rlast),
        .wr_done(m_wr_done), .err(m_err)
    );

    burst_memory_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .BURST_LEN(BL), .READ_LAT(RLZ)) dut_z (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(req_write),
        .req_single(req_single), .req_addr(req_addr),
        .wdata_valid(wdata_valid), .wdata_ready(z_wdata_ready), .wdata(wdata), .wstrb(wstrb),
        .rdata_valid(z_rdata_valid), .rdata_ready(rdata_ready), .rdata(z_rdata), .rlast(z_rlast),
        .wr_done(z_wr_done), .err(z_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference store for the main instance: word index -> contents.
    logic [31:0] model_m [int];

    // Transaction inputs and observations shared by the drivers and tests.
    logic [31:0] wr_data [BL];
    logic [3:0]  wr_strb [BL];
    logic [31:0] obs_data [BL];
    bit          obs_last [BL];
    bit          obs_err  [BL];
    int          obs_n, obs_lat, obs_unstable, obs_whs, obs_done_cnt;
    bit          obs_done_err, obs_extra;

    function automatic int beat_word(int base, int k, bit single);
        return single ? base : (base / BL) * BL + (base + k) % BL;
    endfunction

    function automatic logic [31:0] model_read(int w);
        if (w >= DEPTH) return 32'h0;
        return model_m.exists(w) ? model_m[w] : 32'h0;
    endfunction

    task automatic model_write(int base, bit single);
        int w;
        logic [31:0] v;
        for (int k = 0; k < (single ? 1 : BL); k++) begin
            w = beat_word(base, k, single);
            if (w < DEPTH) begin
                v = model_read(w);
                for (int b = 0; b < 4; b++)
                    if (wr_strb[k][b]) v[8*b +: 8] = wr_data[k][8*b +: 8];
                model_m[w] = v;
            end
        end
    endtask

    // Presents a request at a falling edge and returns at the falling edge
    // that follows the accepting rising edge.
    task automatic issue_req(input bit write, input bit single, input logic [31:0] addr);
        int guard;
        guard      = 0;
        req_valid  = 1'b1;
        req_write  = write;
        req_single = single;
        req_addr   = addr;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random.
    task automatic do_read(input bit single, input logic [31:0] addr, input int mode);
        int n, i, vcount;
        bit stalled, held_last;
        logic [31:0] held;
        n = single ? 1 : BL;
        i = 0; vcount = 0; stalled = 0; held = 0; held_last = 0;
        obs_n = 0; obs_lat = -1; obs_unstable = 0;
        issue_req(1'b0, single, addr);
        while (obs_n < n && i < 200) begin
            if (rdata_valid) begin
                if (obs_lat < 0) obs_lat = i;
                if (stalled && (rdata !== held || rlast !== held_last)) obs_unstable++;
                case (mode)
                    0:       rdata_ready = 1'b1;
                    1:       rdata_ready = (vcount % 3 == 0);
                    default: rdata_ready = 1'($urandom_range(0, 1));
                endcase
                vcount++;
                if (rdata_ready) begin
                    obs_data[obs_n] = rdata;
                    obs_last[obs_n] = rlast;
                    obs_err[obs_n]  = err;
                    obs_n++;
                    stalled = 0;
                end else begin
                    stalled   = 1;
                    held      = rdata;
                    held_last = rlast;
                end
            end else begin
                rdata_ready = 1'b0;
            end
            @(negedge clk);
            i++;
        end
        rdata_ready = 1'b0;
        obs_extra   = rdata_valid;
    endtask

    task automatic do_write(input bit single, input logic [31:0] addr);
        int n, k, i;
        n = single ? 1 : BL;
        k = 0; i = 0;
        obs_done_cnt = 0; obs_done_err = 0;
        issue_req(1'b1, single, addr);
        while (k < n && i < 200) begin
            wdata_valid = ($urandom_range(0, 3) != 0);
            wdata       = wr_data[k];
            wstrb       = wr_strb[k];
            if (wdata_valid && wdata_ready) k++;
            @(negedge clk);
            i++;
        end
        wdata_valid = 1'b0;
        obs_whs = k;
        for (int j = 0; j < 4; j++) begin
            if (wr_done) begin
                obs_done_cnt++;
                obs_done_err = err;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (req_ready !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_req_ready got %b expected 1", req_ready); end
        tests_run++;
        if ({rdata_valid, rlast, wr_done, err, wdata_ready} !== 5'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags got %b expected 00000", {rdata_valid, rlast, wr_done, err, wdata_ready});
        end
        tests_run++;
        if (rdata !== 32'h0) begin tests_failed++; $display("[TB] FAIL reset_rdata got %h expected 0", rdata); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic fill_memory();
        for (int b = 0; b < 16; b++) begin
            for (int k = 0; k < BL; k++) begin
                wr_data[k] = $urandom;
                wr_strb[k] = 4'hF;
            end
            do_write(1'b0, 32'(b * 16));
            model_write(b * 4, 1'b0);
        end
    endtask

    task automatic test_spec_burst();
        logic [31:0] exp_data [BL];
        exp_data[0] = 32'hA2A2A2A2; exp_data[1] = 32'hA3A3A3A3;
        exp_data[2] = 32'hA0A0A0A0; exp_data[3] = 32'hA1A1A1A1;
        for (int k = 0; k < BL; k++) begin
            wr_data[k] = {4{8'hA0 + 8'(k)}};
            wr_strb[k] = 4'hF;
        end
        do_write(1'b0, 32'h10);
        model_write(4, 1'b0);
        tests_run++;
        if (obs_whs !== 4 || obs_done_cnt !== 1 || obs_done_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL spec_write handshakes=%0d done=%0d err=%b expected 4 1 0", obs_whs, obs_done_cnt, obs_done_err);
        end
        do_read(1'b0, 32'h18, 0);
        tests_run++;
        if (obs_lat !== RL + 1) begin tests_failed++; $display("[TB] FAIL spec_latency got %0d expected %0d", obs_lat, RL + 1); end
        tests_run++;
        if (obs_n !== BL) begin tests_failed++; $display("[TB] FAIL spec_beats got %0d expected %0d", obs_n, BL); end
        for (int k = 0; k < obs_n; k++) begin
            tests_run++;
            if (obs_data[k] !== exp_data[k] || obs_last[k] !== (k == BL - 1) || obs_err[k] !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL spec_beat%0d got %h last=%b err=%b expected %h last=%b err=0",
                         k, obs_data[k], obs_last[k], obs_err[k], exp_data[k], (k == BL - 1));
            end
        end
    endtask

    task automatic test_strobe();
        wr_data[0] = 32'hFFFFFFFF; wr_strb[0] = 4'hF;
        do_write(1'b1, 32'h20);
        model_write(8, 1'b1);
        wr_data[0] = 32'h11223344; wr_strb[0] = 4'h5;
        do_write(1'b1, 32'h20);
        model_write(8, 1'b1);
        tests_run++;
        if (obs_done_cnt !== 1 || obs_done_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL strobe_done count=%0d err=%b expected 1 0", obs_done_cnt, obs_done_err);
        end
        do_read(1'b1, 32'h20, 0);
        tests_run++;
        if (obs_n !== 1 || obs_data[0] !== 32'hFF22FF44 || obs_last[0] !== 1'b1 || obs_err[0] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL strobe_read n=%0d got %h last=%b err=%b expected 1 ff22ff44 1 0",
                     obs_n, obs_data[0], obs_last[0], obs_err[0]);
        end
    endtask

    task automatic test_stall();
        do_read(1'b0, 32'h44, 1);
        tests_run++;
        if (obs_n !== BL || obs_unstable !== 0 || obs_extra !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_hold beats=%0d unstable=%0d extra=%b expected %0d 0 0", obs_n, obs_unstable, obs_extra, BL);
        end
        for (int k = 0; k < obs_n; k++) begin
            tests_run++;
            if (obs_data[k] !== model_read(beat_word(17, k, 1'b0)) || obs_last[k] !== (k == BL - 1)) begin
                tests_failed++;
                $display("[TB] FAIL stall_beat%0d got %h last=%b expected %h", k, obs_data[k], obs_last[k],
                         model_read(beat_word(17, k, 1'b0)));
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < BL; k++) begin
            wr_data[k] = $urandom;
            wr_strb[k] = 4'hF;
        end
        do_write(1'b0, 32'(DEPTH * 4));
        tests_run++;
        if (obs_whs !== BL || obs_done_cnt !== 1 || obs_done_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL oor_write handshakes=%0d done=%0d err=%b expected %0d 1 1", obs_whs, obs_done_cnt, obs_done_err, BL);
        end
        do_read(1'b1, 32'h0, 0);
        tests_run++;
        if (obs_data[0] !== model_read(0)) begin
            tests_failed++;
            $display("[TB] FAIL oor_word0 got %h expected %h", obs_data[0], model_read(0));
        end
        do_read(1'b0, 32'(DEPTH * 4), 2);
        tests_run++;
        if (obs_n !== BL) begin tests_failed++; $display("[TB] FAIL oor_read_beats got %0d expected %0d", obs_n, BL); end
        for (int k = 0; k < obs_n; k++) begin
            tests_run++;
            if (obs_data[k] !== 32'h0 || obs_err[k] !== (k == BL - 1) || obs_last[k] !== (k == BL - 1)) begin
                tests_failed++;
                $display("[TB] FAIL oor_beat%0d got %h err=%b last=%b expected 0 err=%b", k, obs_data[k], obs_err[k],
                         obs_last[k], (k == BL - 1));
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int i;
        i = 0;
        issue_req(1'b0, 1'b0, 32'h30);
        while (!rdata_valid && i < 20) begin
            @(negedge clk);
            i++;
        end
        rdata_ready = 1'b1;
        @(negedge clk);
        rdata_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if (rdata_valid !== 1'b0 || req_ready !== 1'b1 || rlast !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_async valid=%b req_ready=%b rlast=%b expected 0 1 0", rdata_valid, req_ready, rlast);
        end
        @(negedge clk);
        tests_run++;
        if (rdata_valid !== 1'b0 || req_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midreset_held valid=%b req_ready=%b expected 0 1", rdata_valid, req_ready);
        end
        reset = 1'b1;
        @(negedge clk);
        do_read(1'b0, 32'h30, 0);
        tests_run++;
        if (obs_n !== BL) begin tests_failed++; $display("[TB] FAIL midreset_beats got %0d expected %0d", obs_n, BL); end
        for (int k = 0; k < obs_n; k++) begin
            tests_run++;
            if (obs_data[k] !== model_read(beat_word(12, k, 1'b0))) begin
                tests_failed++;
                $display("[TB] FAIL midreset_beat%0d got %h expected %h", k, obs_data[k], model_read(beat_word(12, k, 1'b0)));
            end
        end
    endtask

    task automatic test_random();
        bit write, single, oor;
        int word, n;
        for (int t = 0; t < 30; t++) begin
            write  = 1'($urandom_range(0, 1));
            single = 1'($urandom_range(0, 1));
            oor    = ($urandom_range(0, 7) == 0);
            word   = oor ? DEPTH + int'($urandom_range(0, 63)) : int'($urandom_range(0, 63));
            n      = single ? 1 : BL;
            if (write) begin
                for (int k = 0; k < BL; k++) begin
                    wr_data[k] = $urandom;
                    wr_strb[k] = 4'($urandom_range(0, 15));
                end
                do_write(single, 32'(word * 4 + int'($urandom_range(0, 3))));
                model_write(word, single);
                tests_run++;
                if (obs_whs !== n || obs_done_cnt !== 1 || obs_done_err !== oor) begin
                    tests_failed++;
                    $display("[TB] FAIL rand_write%0d handshakes=%0d done=%0d err=%b expected %0d 1 %b",
                             t, obs_whs, obs_done_cnt, obs_done_err, n, oor);
                end
            end else begin
                do_read(single, 32'(word * 4 + int'($urandom_range(0, 3))), 2);
                tests_run++;
                if (obs_n !== n) begin tests_failed++; $display("[TB] FAIL rand_read%0d beats got %0d expected %0d", t, obs_n, n); end
                for (int k = 0; k < obs_n; k++) begin
                    tests_run++;
                    if (obs_data[k] !== model_read(beat_word(word, k, single)) || obs_last[k] !== (k == n - 1) ||
                        obs_err[k] !== (oor && k == n - 1)) begin
                        tests_failed++;
                        $display("[TB] FAIL rand_read%0d_beat%0d got %h last=%b err=%b expected %h last=%b err=%b",
                                 t, k, obs_data[k], obs_last[k], obs_err[k], model_read(beat_word(word, k, single)),
                                 (k == n - 1), (oor && k == n - 1));
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        wr_data[0] = $urandom; wr_strb[0] = 4'hF;
        do_write(1'b1, 32'h14);
        model_write(5, 1'b1);
        do_read(1'b1, 32'h14, 0);
        tests_run++;
        if (obs_data[0] !== wr_data[0]) begin
            tests_failed++;
            $display("[TB] FAIL raw_same_word got %h expected %h", obs_data[0], wr_data[0]);
        end
    endtask

    task automatic test_zero_latency();
        logic [31:0] zdat [BL];
        logic [31:0] seen [2*BL];
        bit          seen_last [2*BL];
        int acc [2];
        int nacc, nbeat, i, expw;
        bit drop;
        sel_z = 1'b1;
        @(negedge clk);
        for (int k = 0; k < BL; k++) begin
            zdat[k]    = $urandom;
            wr_data[k] = zdat[k];
            wr_strb[k] = 4'hF;
        end
        do_write(1'b0, 32'h40);
        tests_run++;
        if (obs_done_cnt !== 1) begin tests_failed++; $display("[TB] FAIL zlat_write done=%0d expected 1", obs_done_cnt); end
        do_read(1'b0, 32'h40, 0);
        tests_run++;
        if (obs_lat !== RLZ + 1 || obs_n !== BL) begin
            tests_failed++;
            $display("[TB] FAIL zlat_latency got %0d beats=%0d expected %0d %0d", obs_lat, obs_n, RLZ + 1, BL);
        end
        // Request held across two bursts; the second accept must wait for IDLE.
        nacc = 0; nbeat = 0; i = 0; drop = 0;
        acc[0] = 0; acc[1] = 0;
        req_valid = 1'b1; req_write = 1'b0; req_single = 1'b0; req_addr = 32'h48;
        rdata_ready = 1'b1;
        while (nbeat < 2 * BL && i < 80) begin
            if (drop) req_valid = 1'b0;
            if (req_valid && req_ready) begin
                acc[nacc] = i;
                nacc++;
                if (nacc == 2) drop = 1;
            end
            if (rdata_valid) begin
                seen[nbeat]      = rdata;
                seen_last[nbeat] = rlast;
                nbeat++;
            end
            @(negedge clk);
            i++;
        end
        req_valid = 1'b0;
        rdata_ready = 1'b0;
        tests_run++;
        if (nacc !== 2 || acc[1] - acc[0] !== RLZ + 1 + BL + 1) begin
            tests_failed++;
            $display("[TB] FAIL zlat_held_accepts count=%0d gap=%0d expected 2 %0d", nacc, acc[1] - acc[0], RLZ + BL + 2);
        end
        for (int j = 0; j < nbeat; j++) begin
            expw = beat_word(18, j % BL, 1'b0) - 16;
            tests_run++;
            if (seen[j] !== zdat[expw] || seen_last[j] !== (j % BL == BL - 1)) begin
                tests_failed++;
                $display("[TB] FAIL zlat_beat%0d got %h last=%b expected %h", j, seen[j], seen_last[j], zdat[expw]);
            end
        end
        @(negedge clk);
        sel_z = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired before summary, failed so far %0d", tests_failed);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_single  = 1'b0;
        req_addr    = 32'h0;
        wdata_valid = 1'b0;
        wdata       = 32'h0;
        wstrb       = 4'h0;
        rdata_ready = 1'b0;
        sel_z       = 1'b0;
        test_reset();
        fill_memory();
        test_spec_burst();
        test_strobe();
        test_stall();
        test_out_of_range();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        test_zero_latency();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/burst_memory_ctrl.md
Name: burst_memory_ctrl

Overview:
- Parametrised successor to the single-width main memory model: word-organised backing store with configurable data width, depth, burst length and read latency.
- Adds valid/ready handshakes on request, write-data and read-data channels, per-byte write strobes, and critical-word-first wrapping bursts.
- Adds out-of-range error reporting.
- Sits between the cache/MESI controller and the backing store; serves cache-line fills and write-backs.

Parameters:
- DATA_W, 32, data bus width in bits; multiple of 8, minimum 16.
- ADDR_W, 32, byte address width.
- DEPTH, 4096, number of DATA_W words in the store; power of two.
- BURST_LEN, 4, beats per burst; power of two, at least 2.
- READ_LAT, 2, wait cycles between read accept and first beat; 0 allowed.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_single  in  1  1 = single beat, 0 = BURST_LEN beats.
- req_addr  in  ADDR_W  byte address of the first (critical) word; low log2(DATA_W/8) bits ignored.
- wdata_valid  in  1  write beat present.
- wdata_ready  out  1  write beat accepted when asserted with wdata_valid.
- wdata  in  DATA_W  write beat data.
- wstrb  in  DATA_W/8  byte enables; bit i covers wdata[8i+7:8i].
- rdata_valid  out  1  read beat present.
- rdata_ready  in  1  consumer takes the beat.
- rdata  out  DATA_W  read beat data.
- rlast  out  1  final beat of a read.
- wr_done  out  1  one-cycle pulse when a write burst completes.
- err  out  1  out-of-range flag; qualified by rlast with rdata_valid, or by wr_done.

Behaviour:
- Reset (reset low, asynchronous):
  - State goes to IDLE.
  - rdata_valid, rlast, wr_done, err, wdata_ready go to 0; rdata goes to 0; internal counters clear.
  - Store contents are not reset.
  - Reset mid-burst abandons the burst; beats already written stay committed.
- req_ready is 1 exactly while in IDLE, including during reset. A request is accepted on an edge with req_valid and req_ready both high.
- Latched at accept:
  - Word index = req_addr >> log2(DATA_W/8).
  - Beat count = 1 if req_single, else BURST_LEN.
  - err_latched = word index >= DEPTH.
- Wrap rule: beat k uses word (base & ~(BURST_LEN-1)) | ((base + k) & (BURST_LEN-1)), i.e. it wraps within the BURST_LEN-aligned block. Single beats use base only.
- States:
  - IDLE -> RD_WAIT on a read accept, or RD_BEAT directly if READ_LAT = 0.
  - IDLE -> WR_BEAT on a write accept.
  - RD_WAIT: counts READ_LAT cycles, then -> RD_BEAT.
  - RD_BEAT:
    - rdata_valid = 1, holding rdata and rlast stable until rdata_ready.
    - Each handshake advances the beat; the next beat is presented the following cycle with no bubble.
    - rlast is asserted on the final beat.
    - After the final handshake -> IDLE.
  - WR_BEAT:
    - wdata_ready = 1.
    - Each wdata handshake writes the bytes with wstrb = 1 to the beat's word; bytes with wstrb = 0 are unchanged.
    - After the final beat -> WR_RESP.
  - WR_RESP: wr_done = 1 for one cycle with err = err_latched, then -> IDLE (req_ready next cycle).
- Read latency: for an accept at edge T, the first rdata_valid is visible after edge T+READ_LAT+1.
- Out of range:
  - Reads return all-zero data for every beat; err = 1 on the rlast beat.
  - Writes complete the full handshake but modify nothing; err = 1 with wr_done.
  - err is 0 at all other times.
- Requests arriving outside IDLE are not accepted; req_valid must be held by the requester.
- Write data presented while not in WR_BEAT is ignored; wdata_ready = 0.
- Read-after-write to the same word in back-to-back bursts returns the new data.

Test Plan:
- Reset low mid-read (second beat pending) -> state IDLE, rdata_valid = 0, req_ready = 1 while reset held; a new read after release returns correct data.
- Write burst at 0x10, beats 0xA0A0A0A0..0xA3A3A3A3, wstrb 0xF; read burst at 0x18 -> beats in order 0xA2A2A2A2, 0xA3A3A3A3, 0xA0A0A0A0, 0xA1A1A1A1; rlast on the 4th beat; first beat 3 cycles after accept (READ_LAT = 2).
- Single write at 0x20 of 0x11223344 with wstrb 0x5 over prior 0xFFFFFFFF -> single read returns 0xFF22FF44; wr_done pulses once with err = 0.
- Read burst with rdata_ready toggling 1,0,0,1,... -> every beat held stable while stalled; no beat lost or duplicated; exactly 4 handshakes.
- Write to byte address DEPTH*4 -> 4 wdata handshakes accepted, wr_done with err = 1; word 0 unchanged.
- Read at DEPTH*4 -> 4 zero beats, err = 1 on the rlast beat.
- READ_LAT = 0 build: read accept at edge T -> rdata_valid high after edge T+1; req_valid held during the burst -> next accept occurs only after return to IDLE.
